// File: rtl/seg_display_scan.sv
// Time-multiplexed 8-digit common-anode seven-segment driver.
// Scans one hex nibble of a shadowed word per SCAN_DIV cycles, with optional leading-zero blanking.
module seg_display_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] value,
    input  logic        halt,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [31:0]   shadow;
    logic [CW-1:0] div_cnt;
    logic [2:0]    idx;
    logic          tick;
    logic [7:0]    nz;
    logic          blank;
    logic [3:0]    nib;
    logic [7:0]    an_d;
    logic [7:0]    seg_d;

    assign tick = (div_cnt == CW'(SCAN_DIV - 1));

    // nz[i] set when any nibble from i upward is non-zero
    for (genvar i = 0; i < 8; i++) begin : g_nz
        assign nz[i] = |shadow[31:4*i];
    end

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] p;
        case (h)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    always_comb begin
        nib   = shadow[{idx, 2'b00} +: 4];
        blank = blank_lz && (idx != 3'd0) && !nz[idx];
        an_d  = blank ? 8'hFF : ~(8'b1 << idx);
        seg_d[6:0] = blank ? 7'h7F : hex7(nib);
        seg_d[7]   = !((idx == 3'd0) && halt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            div_cnt <= '0;
            idx     <= '0;
            an      <= 8'hFF;
            seg     <= 8'hFF;
        end else begin
            if (load) shadow <= value;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) idx <= idx + 3'd1;
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: one instance at SCAN_DIV=4, one at SCAN_DIV=1, shared inputs.
module tb_seg_display_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [31:0] value;
    logic        halt;
    logic        blank_lz;
    logic [7:0]  an4, seg4, an1, seg1;

    int checks = 0;
    int failures = 0;
    int n = 0;

    // expected seg per digit for 89ABCDEF (dp off) and 76543210 (dp off)
    logic [7:0] p_scan [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] p_seq  [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    seg_display_scan #(.SCAN_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .halt(halt),
        .blank_lz(blank_lz), .an(an4), .seg(seg4)
    );

    seg_display_scan #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .halt(halt),
        .blank_lz(blank_lz), .an(an1), .seg(seg1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b1; value = 32'h12345678; halt = 1'b0; blank_lz = 1'b0;

        // reset held while clocking with load active
        repeat (3) begin
            step();
            chk("rst_an4", an4, 8'hFF);
            chk("rst_seg4", seg4, 8'hFF);
            chk("rst_an1", an1, 8'hFF);
        end

        // release; shadow load of 89ABCDEF lands at edge 1, shown from edge 2
        value = 32'h89ABCDEF;
        rst_n = 1'b1;
        n = 0;
        step();
        load = 1'b0;
        chk("post_rst_an", an4, 8'hFE);
        chk("post_rst_seg", seg4, 8'hC0);

        // full scan: digit = (n-1)/4 mod 8
        while (n < 33) begin
            step();
            chk("scan_an", an4, ~(8'b1 << (((n - 1) / 4) % 8)));
            chk("scan_seg", seg4, p_scan[((n - 1) / 4) % 8]);
        end

        // leading-zero suppression with 00000A05
        blank_lz = 1'b1; load = 1'b1; value = 32'h00000A05;
        step();                                  // n=34, old shadow still shown
        load = 1'b0;
        chk("lz_d0_old", seg4, 8'h8E);
        step(); chk("lz_an0", an4, 8'hFE); chk("lz_seg0", seg4, 8'h92);
        step();
        step(); chk("lz_an1", an4, 8'hFD); chk("lz_seg1", seg4, 8'hC0);
        repeat (4) step();                       // n=41
        chk("lz_an2", an4, 8'hFB); chk("lz_seg2", seg4, 8'h88);
        while (n < 64) begin
            step();
            if (n >= 45) begin
                chk("lz_blank_an", an4, 8'hFF);
                chk("lz_blank_seg", seg4, 8'hFF);
            end
        end

        // zero value with blanking, then halt dp on digit 0
        load = 1'b1; value = 32'h0;
        step();                                  // n=65
        load = 1'b0;
        chk("zero_old_seg", seg4, 8'h92);
        halt = 1'b1;
        while (n < 68) begin
            step();
            chk("halt_an0", an4, 8'hFE);
            chk("halt_seg0", seg4, 8'h40);
        end
        while (n < 96) begin
            step();
            chk("zero_dark_an", an4, 8'hFF);
            chk("zero_dark_seg", seg4, 8'hFF);
        end
        halt = 1'b0; blank_lz = 1'b0;
        step(); chk("nohalt_seg0", seg4, 8'hC0);  // n=97

        // load coinciding with the 7->0 tick at edge 128
        while (n < 127) step();
        load = 1'b1; value = 32'h00000003;
        step();                                  // n=128
        load = 1'b0;
        chk("simul_pre_an", an4, 8'h7F);
        chk("simul_pre_seg", seg4, 8'hC0);
        step(); chk("simul_an", an4, 8'hFE); chk("simul_seg", seg4, 8'hB0);
        step(); chk("simul_hold_seg", seg4, 8'hB0);

        // asynchronous reset mid-scan
        rst_n = 1'b0;
        #2;
        chk("async_an4", an4, 8'hFF);
        chk("async_seg4", seg4, 8'hFF);
        chk("async_an1", an1, 8'hFF);
        chk("async_seg1", seg1, 8'hFF);

        // SCAN_DIV=1: rotates every cycle, halt dp only on digit 0
        halt = 1'b1; load = 1'b1; value = 32'h76543210;
        step();
        chk("rst2_seg1", seg1, 8'hFF);
        rst_n = 1'b1;
        n = 0;
        step();
        load = 1'b0;
        chk("d1_an_first", an1, 8'hFE);
        chk("d1_seg_first", seg1, 8'h40);
        chk("d4_seg_first", seg4, 8'h40);
        while (n < 9) begin
            step();
            chk("d1_an", an1, ~(8'b1 << ((n - 1) % 8)));
            chk("d1_seg", seg1, (((n - 1) % 8) == 0) ? 8'h40 : p_seq[(n - 1) % 8]);
        end
        halt = 1'b0;
        while (n < 17) begin
            step();
            chk("d1_an_nh", an1, ~(8'b1 << ((n - 1) % 8)));
            chk("d1_seg_nh", seg1, p_seq[(n - 1) % 8]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
